dff_bank_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit register (a bank of asynchronously reset D flip-flops) among N_REQ requesters. It grants exclusive write ownership to one requester at a time and bounds each ownership to MAX_HOLD cycles. It forces a one-cycle idle gap between owners. It sits between several control agents and a single shared state register, which it both sequences and holds.

---
 rtl/dff_bank_arbiter.sv | 124 ++++++++++++
 tb/tb_dff_bank_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter granting exclusive, time-bounded write ownership of one
// shared WIDTH-bit register to N_REQ requesters, with a forced idle gap between owners.
module dff_bank_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   ar,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       we,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   busy,
  output logic [2:0]             owner
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [2:0]       owner_nxt;
  logic [3:0]       hold, hold_nxt;
  logic [2:0]       ptr, ptr_nxt;
  logic [WIDTH-1:0] q_nxt;

  logic             any_req;
  logic [2:0]       win;
  logic [N_REQ-1:0] win_oh;
  logic             own_req;
  logic             own_we;
  logic [WIDTH-1:0] wsel;

  // Winner is the set req bit at the smallest rotational distance from ptr.
  always_comb begin
    int best_d;
    int d;
    win    = '0;
    win_oh = '0;
    best_d = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      d = i - int'(ptr);
      if (d < 0) d = d + N_REQ;
      if (req[i] && d < best_d) begin
        best_d = d;
        win    = 3'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) win_oh[i] = (win == 3'(i));
  end

  // gnt is one-hot, so masking picks out the owner's request, enable and data.
  always_comb begin
    wsel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) wsel = wdata[i*WIDTH +: WIDTH];
  end

  assign any_req = |req;
  assign own_req = |(req & gnt);
  assign own_we  = |(we & req & gnt);
  assign busy    = |gnt;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    hold_nxt  = hold;
    ptr_nxt   = ptr;
    q_nxt     = q;
    case (state)
      IDLE, GAP: begin
        if (any_req) begin
          state_nxt = GRANT;
          gnt_nxt   = win_oh;
          owner_nxt = win;
          hold_nxt  = 4'd1;
          ptr_nxt   = (win == 3'(N_REQ - 1)) ? 3'd0 : win + 3'd1;
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!own_req) begin
          state_nxt = GAP;
          gnt_nxt   = '0;
        end else begin
          if (own_we) q_nxt = wsel;
          if (hold == 4'(MAX_HOLD)) begin
            state_nxt = GAP;
            gnt_nxt   = '0;
          end else begin
            hold_nxt = hold + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      hold  <= '0;
      ptr   <= '0;
      q     <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      owner <= owner_nxt;
      hold  <= hold_nxt;
      ptr   <= ptr_nxt;
      q     <= q_nxt;
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter with hand-computed expected values.
module tb_dff_bank_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int MAX_HOLD = 4;

  logic                   clk = 1'b0;
  logic                   ar;
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       we;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       q;
  logic                   busy;
  logic [2:0]             owner;

  int checks = 0;
  int errors = 0;

  dff_bank_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .ar(ar), .req(req), .we(we), .wdata(wdata),
    .gnt(gnt), .q(q), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    ar = 1'b1;
    #2;
    req = '0;
    we  = '0;
    ar  = 1'b0;
    tick();
  endtask

  initial begin
    ar = 1'b1;
    req = '0;
    we = '0;
    wdata = '0;

    // Reset held with random inputs, checked on both sides of the edge.
    for (int c = 0; c < 3; c++) begin
      req   = 4'($urandom);
      we    = 4'($urandom);
      wdata = 32'($urandom);
      @(posedge clk);
      #1;
      chk("rst_gnt_edge", 32'(gnt), 32'h0);
      chk("rst_q_edge", 32'(q), 32'h0);
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_owner", 32'(owner), 32'h0);
    end
    req = '0;
    we = '0;
    wdata = '0;
    ar = 1'b0;
    tick();
    chk("idle_gnt", 32'(gnt), 32'h0);

    // Single requester 2 with writes, hold limit, gap, re-grant.
    req = 4'b0100;
    we = 4'b0100;
    wdata[23:16] = 8'hA5;
    tick();
    chk("single_gnt1", 32'(gnt), 32'h4);
    chk("single_owner", 32'(owner), 32'h2);
    chk("single_q_prewrite", 32'(q), 32'h0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("single_gnt_hold", 32'(gnt), 32'h4);
      chk("single_q", 32'(q), 32'hA5);
    end
    tick();
    chk("single_gap_gnt", 32'(gnt), 32'h0);
    chk("single_gap_busy", 32'(busy), 32'h0);
    tick();
    chk("single_regrant", 32'(gnt), 32'h4);
    chk("single_regrant_busy", 32'(busy), 32'h1);
    req = '0;
    we = '0;
    tick();
    chk("single_release", 32'(gnt), 32'h0);

    // Round robin with all requesting, pointer starting from 0.
    pulse_reset();
    req = 4'b1111;
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      for (int g = 0; g < 5; g++) begin
        for (int h = 0; h < MAX_HOLD; h++) begin
          tick();
          chk("rr_gnt", 32'(gnt), 32'(1 << order[g]));
          chk("rr_owner", 32'(owner), 32'(order[g]));
        end
        tick();
        chk("rr_gap", 32'(gnt), 32'h0);
      end
    end
    chk("rr_q", 32'(q), 32'h0);
    req = '0;
    tick();

    // Non-owner isolation on owner 1.
    pulse_reset();
    req = 4'b0010;
    tick();
    chk("iso_gnt", 32'(gnt), 32'h2);
    we = 4'b1000;
    wdata = '0;
    wdata[31:24] = 8'hFF;
    tick();
    chk("iso_q_unchanged", 32'(q), 32'h0);
    we = 4'b0010;
    wdata[15:8] = 8'h3C;
    tick();
    chk("iso_q_write", 32'(q), 32'h3C);
    chk("iso_gnt_still", 32'(gnt), 32'h2);

    // Asynchronous reset between edges while owner 1 holds q=0x3C.
    #2;
    ar = 1'b1;
    #1;
    chk("ar_gnt", 32'(gnt), 32'h0);
    chk("ar_q", 32'(q), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_owner", 32'(owner), 32'h0);
    we = '0;
    ar = 1'b0;
    tick();
    chk("ar_regrant", 32'(gnt), 32'h2);
    chk("ar_owner1", 32'(owner), 32'h1);

    // Early release by owner 0 with a simultaneous write that must be dropped.
    pulse_reset();
    req = 4'b0011;
    we = 4'b0001;
    wdata = '0;
    wdata[7:0] = 8'h11;
    tick();
    chk("early_gnt0", 32'(gnt), 32'h1);
    tick();
    chk("early_q", 32'(q), 32'h11);
    req = 4'b0010;
    wdata[7:0] = 8'h77;
    tick();
    chk("early_gap", 32'(gnt), 32'h0);
    chk("early_nowrite", 32'(q), 32'h11);
    tick();
    chk("early_next", 32'(gnt), 32'h2);
    chk("early_owner", 32'(owner), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
